// File: rtl/cpu_control_mc.sv
// Multi-cycle control unit for a small LEGv8-style datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// handles memory handshakes with a timeout, and reports halt/fault status and retired instructions.
module cpu_control_mc #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      inst31_21,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             InstRead,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Reg2Loc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             PCSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrc,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_LDUR, OP_STUR, OP_RTYPE, OP_ADDI, OP_CBZ, OP_CBNZ, OP_B, OP_HALT, OP_ILL
  } opclass_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  opclass_t         w_class;
  logic [10:0]      r_opcode;
  logic [7:0]       r_wait;
  logic [1:0]       r_fault_code;
  logic [1:0]       w_fault_code_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_load_op;
  logic             w_wait_inc;
  logic             w_timeout;
  logic             w_retire;

  always_comb begin
    w_class = OP_ILL;
    if (r_opcode == 11'b11111000010) w_class = OP_LDUR;
    else if (r_opcode == 11'b11111000000) w_class = OP_STUR;
    else if (r_opcode == 11'b10001011000 || r_opcode == 11'b11001011000 ||
             r_opcode == 11'b10001010000 || r_opcode == 11'b10101010000) w_class = OP_RTYPE;
    else if (r_opcode[10:1] == 10'b1001000100) w_class = OP_ADDI;
    else if (r_opcode[10:3] == 8'b10110100) w_class = OP_CBZ;
    else if (r_opcode[10:3] == 8'b10110101) w_class = OP_CBNZ;
    else if (r_opcode[10:5] == 6'b000101) w_class = OP_B;
    else if (r_opcode == 11'b11111111111) w_class = OP_HALT;
  end

  // The timeout fires on the MEM_TIMEOUT-th consecutive waiting cycle; a ready in that cycle still wins.
  assign w_timeout = (r_wait == LP_WAIT_LAST);

  always_comb begin
    w_next            = r_state;
    w_fault_code_next = r_fault_code;
    w_load_op         = 1'b0;
    w_wait_inc        = 1'b0;
    InstRead = 1'b0; IRWrite  = 1'b0; PCWrite  = 1'b0; Reg2Loc  = 1'b0;
    MemRead  = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    PCSrc    = 1'b0; ALUOp    = 2'b00; ALUSrc  = 2'b00;
    case (r_state)
      S_FETCH: begin
        InstRead = 1'b1;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          w_load_op = 1'b1;
          w_next    = S_DECODE;
        end else if (w_timeout) begin
          w_next            = S_FAULT;
          w_fault_code_next = 2'd2;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        case (w_class)
          OP_ILL: begin
            w_next            = S_FAULT;
            w_fault_code_next = 2'd1;
          end
          OP_HALT: w_next = S_HALT;
          OP_B: begin
            PCWrite = 1'b1;
            PCSrc   = 1'b1;
            w_next  = S_FETCH;
          end
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (w_class)
          OP_LDUR, OP_STUR: begin
            ALUSrc  = 2'b01;
            Reg2Loc = (w_class == OP_STUR);
            w_next  = S_MEM;
          end
          OP_RTYPE: begin
            ALUOp  = 2'b10;
            w_next = S_WB;
          end
          OP_ADDI: begin
            ALUOp  = 2'b10;
            ALUSrc = 2'b10;
            w_next = S_WB;
          end
          OP_CBZ, OP_CBNZ: begin
            ALUOp   = 2'b01;
            Reg2Loc = 1'b1;
            if ((w_class == OP_CBZ) == zero) begin
              PCWrite = 1'b1;
              PCSrc   = 1'b1;
            end
            w_next = S_FETCH;
          end
          default: begin
            w_next            = S_FAULT;
            w_fault_code_next = 2'd1;
          end
        endcase
      end
      S_MEM: begin
        // Address operands stay selected while the memory access is outstanding.
        ALUSrc   = 2'b01;
        MemRead  = (w_class == OP_LDUR);
        MemWrite = (w_class != OP_LDUR);
        if (mem_ready) begin
          w_next = (w_class == OP_LDUR) ? S_WB : S_FETCH;
        end else if (w_timeout) begin
          w_next            = S_FAULT;
          w_fault_code_next = 2'd2;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (w_class == OP_LDUR);
        w_next   = S_FETCH;
      end
      S_HALT, S_FAULT: w_next = r_state;
      default: begin
        w_next            = S_FAULT;
        w_fault_code_next = 2'd1;
      end
    endcase
    if (reset) begin
      InstRead = 1'b0; IRWrite  = 1'b0; PCWrite  = 1'b0; Reg2Loc  = 1'b0;
      MemRead  = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
      PCSrc    = 1'b0; ALUOp    = 2'b00; ALUSrc  = 2'b00;
    end
  end

  assign w_retire = ((w_next == S_FETCH) && (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB})) ||
                    ((w_next == S_HALT) && (r_state != S_HALT));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_opcode     <= 11'd0;
      r_wait       <= 8'd0;
      r_fault_code <= 2'd0;
      r_retired    <= '0;
    end else begin
      r_state      <= w_next;
      r_fault_code <= w_fault_code_next;
      if (w_load_op) r_opcode <= inst31_21;
      if (w_next != r_state) r_wait <= 8'd0;
      else if (w_wait_inc) r_wait <= r_wait + 8'd1;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign state      = r_state;
  assign halted     = (r_state == S_HALT);
  assign fault      = (r_state == S_FAULT);
  assign fault_code = r_fault_code;
  assign retired    = r_retired;

endmodule

// File: tb/tb_cpu_control_mc.sv
// Bench for cpu_control_mc: directed instruction scenarios with literal expectations, then random
// stimulus checked every cycle against a mnemonic-level behavioural model.
module tb_cpu_control_mc;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_CBNZ = 11'b10110101011;
  localparam logic [10:0] OP_HALT = 11'b11111111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [10:0] inst31_21 = 11'd0;
  logic mem_ready = 1'b0;
  logic zero = 1'b0;
  logic InstRead, IRWrite, PCWrite, Reg2Loc, MemRead, MemWrite, MemtoReg, RegWrite, PCSrc;
  logic [1:0] ALUOp, ALUSrc, fault_code;
  logic [2:0] state;
  logic halted, fault;
  logic [CNT_W-1:0] retired;

  int nTests = 0;
  int nFail = 0;

  cpu_control_mc #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .inst31_21(inst31_21), .mem_ready(mem_ready), .zero(zero),
    .InstRead(InstRead), .IRWrite(IRWrite), .PCWrite(PCWrite), .Reg2Loc(Reg2Loc),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .PCSrc(PCSrc), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .state(state), .halted(halted),
    .fault(fault), .fault_code(fault_code), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  function automatic string mnem(input logic [10:0] op);
    casez (op)
      11'b11111000010: return "LDUR";
      11'b11111000000: return "STUR";
      11'b10001011000: return "ADD";
      11'b11001011000: return "SUB";
      11'b10001010000: return "AND";
      11'b10101010000: return "ORR";
      11'b1001000100?: return "ADDI";
      11'b10110100???: return "CBZ";
      11'b10110101???: return "CBNZ";
      11'b000101?????: return "B";
      11'b11111111111: return "HALT";
      default:         return "ILL";
    endcase
  endfunction

  // {ALUOp, ALUSrc} the datapath needs for each instruction's execute step.
  function automatic logic [3:0] aluFields(input string m);
    if (m == "LDUR" || m == "STUR") return 4'b0001;
    if (m == "ADDI") return 4'b1010;
    if (m == "CBZ" || m == "CBNZ") return 4'b0100;
    if (m == "ADD" || m == "SUB" || m == "AND" || m == "ORR") return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic logic [10:0] randOp();
    logic [10:0] r;
    r = 11'($urandom);
    case ($urandom_range(0, 12))
      0, 1:    return OP_LDUR;
      2, 3:    return 11'b11111000000;
      4:       return 11'b11001011000;
      5:       return 11'b10001010000;
      6:       return 11'b10101010000;
      7:       return {10'b1001000100, r[0]};
      8:       return {8'b10110100, r[2:0]};
      9:       return {8'b10110101, r[2:0]};
      10:      return {6'b000101, r[4:0]};
      11:      return ($urandom_range(0, 3) == 0) ? OP_HALT : r;
      default: return OP_ADD;
    endcase
  endfunction

  // Model state uses the architectural state numbering seen on the state port.
  int mState = 0, nState = 0, mWait = 0, nWait = 0, mRet = 0, nRet = 0, mFcode = 0, nFcode = 0, waited;
  logic [10:0] mOp = 11'd0, nOp = 11'd0;
  bit mArmed = 0, nArmed = 0, nValid = 0;
  string m;
  logic [3:0] alu;
  logic eInstRead, eIRWrite, ePCWrite, eReg2Loc, eMemRead, eMemWrite, eMemtoReg, eRegWrite, ePCSrc;
  logic [1:0] eAluOp, eAluSrc;

  always @(negedge clk) begin
    eInstRead = 0; eIRWrite = 0; ePCWrite = 0; eReg2Loc = 0; eMemRead = 0;
    eMemWrite = 0; eMemtoReg = 0; eRegWrite = 0; ePCSrc = 0; eAluOp = 0; eAluSrc = 0;
    nState = mState; nOp = mOp; nWait = mWait; nFcode = mFcode; nRet = mRet; nArmed = mArmed;
    m = mnem(mOp);
    alu = aluFields(m);
    waited = mWait + 1;
    case (mState)
      0: begin
        eInstRead = 1;
        if (mem_ready) begin eIRWrite = 1; ePCWrite = 1; nOp = inst31_21; nState = 1; end
        else if (waited >= MEM_TIMEOUT) begin nState = 6; nFcode = 2; end
        else nWait = waited;
      end
      1: begin
        if (m == "ILL") begin nState = 6; nFcode = 1; end
        else if (m == "HALT") nState = 5;
        else if (m == "B") begin ePCWrite = 1; ePCSrc = 1; nState = 0; end
        else nState = 2;
      end
      2: begin
        {eAluOp, eAluSrc} = alu;
        eReg2Loc = (m == "STUR" || m == "CBZ" || m == "CBNZ");
        if ((m == "CBZ" && zero) || (m == "CBNZ" && !zero)) begin ePCWrite = 1; ePCSrc = 1; end
        nState = (m == "LDUR" || m == "STUR") ? 3 : (m == "CBZ" || m == "CBNZ") ? 0 : 4;
      end
      3: begin
        {eAluOp, eAluSrc} = alu;
        eMemRead = (m == "LDUR");
        eMemWrite = (m == "STUR");
        if (mem_ready) nState = (m == "LDUR") ? 4 : 0;
        else if (waited >= MEM_TIMEOUT) begin nState = 6; nFcode = 2; end
        else nWait = waited;
      end
      4: begin eRegWrite = 1; eMemtoReg = (m == "LDUR"); nState = 0; end
      default: ;
    endcase
    if (nState != mState) nWait = 0;
    if (nState != mState && (nState == 0 || nState == 5)) nRet = (mRet + 1) % (1 << CNT_W);
    if (reset) begin
      eInstRead = 0; eIRWrite = 0; ePCWrite = 0; eReg2Loc = 0; eMemRead = 0;
      eMemWrite = 0; eMemtoReg = 0; eRegWrite = 0; ePCSrc = 0; eAluOp = 0; eAluSrc = 0;
      nState = 0; nOp = 0; nWait = 0; nFcode = 0; nRet = 0; nArmed = 1;
    end
    if (reset || mArmed) begin
      checkOutput("InstRead", InstRead, eInstRead);
      checkOutput("IRWrite", IRWrite, eIRWrite);
      checkOutput("PCWrite", PCWrite, ePCWrite);
      checkOutput("PCSrc", PCSrc, ePCSrc);
      checkOutput("Reg2Loc", Reg2Loc, eReg2Loc);
      checkOutput("MemRead", MemRead, eMemRead);
      checkOutput("MemWrite", MemWrite, eMemWrite);
      checkOutput("MemtoReg", MemtoReg, eMemtoReg);
      checkOutput("RegWrite", RegWrite, eRegWrite);
      checkOutput("ALUOp", ALUOp, eAluOp);
      checkOutput("ALUSrc", ALUSrc, eAluSrc);
    end
    if (mArmed && !reset) begin
      checkOutput("state", state, mState);
      checkOutput("halted", halted, mState == 5);
      checkOutput("fault", fault, mState == 6);
      checkOutput("fault_code", fault_code, mFcode);
      checkOutput("retired", retired, mRet);
    end
    nValid = 1;
  end

  always @(posedge clk) begin
    if (nValid) begin
      mState <= nState; mOp <= nOp; mWait <= nWait; mFcode <= nFcode; mRet <= nRet; mArmed <= nArmed;
    end
  end

  // One call per clock: inputs change just after the rising edge, checks happen at the falling edge.
  task automatic applyStimulus(input logic rst, input logic [10:0] inst, input logic rdy, input logic z);
    @(posedge clk);
    #1;
    reset = rst; inst31_21 = inst; mem_ready = rdy; zero = z;
    @(negedge clk);
  endtask

  initial begin
    // ADD with an immediate fetch handshake.
    applyStimulus(1, OP_ADD, 1, 0);
    checkOutput("lit_reset_InstRead", InstRead, 0);
    applyStimulus(0, OP_ADD, 1, 0);
    checkOutput("lit_add_fetch_state", state, 0);
    checkOutput("lit_add_fetch_InstRead", InstRead, 1);
    checkOutput("lit_add_fetch_IRWrite", IRWrite, 1);
    checkOutput("lit_add_retired0", retired, 0);
    applyStimulus(0, OP_ADD, 0, 0);
    checkOutput("lit_add_decode", state, 1);
    applyStimulus(0, OP_ADD, 0, 0);
    checkOutput("lit_add_exec", state, 2);
    checkOutput("lit_add_aluop", ALUOp, 2);
    applyStimulus(0, OP_ADD, 0, 0);
    checkOutput("lit_add_wb", state, 4);
    checkOutput("lit_add_regwrite", RegWrite, 1);
    applyStimulus(0, OP_ADD, 0, 0);
    checkOutput("lit_add_back_fetch", state, 0);
    checkOutput("lit_add_retired1", retired, 1);
    checkOutput("lit_add_regwrite_off", RegWrite, 0);

    // LDUR with memory ready delayed three cycles.
    applyStimulus(1, OP_LDUR, 0, 0);
    applyStimulus(0, OP_LDUR, 1, 0);
    applyStimulus(0, OP_LDUR, 0, 0);
    applyStimulus(0, OP_LDUR, 0, 0);
    checkOutput("lit_ldur_alusrc", ALUSrc, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, OP_LDUR, 0, 0);
      checkOutput("lit_ldur_memread_wait", MemRead, 1);
    end
    applyStimulus(0, OP_LDUR, 1, 0);
    checkOutput("lit_ldur_memread_last", MemRead, 1);
    applyStimulus(0, OP_LDUR, 0, 0);
    checkOutput("lit_ldur_wb_state", state, 4);
    checkOutput("lit_ldur_memtoreg", MemtoReg, 1);
    applyStimulus(0, OP_LDUR, 0, 0);
    checkOutput("lit_ldur_retired", retired, 1);

    // CBZ taken, then CBNZ not taken.
    applyStimulus(1, OP_CBZ, 0, 0);
    applyStimulus(0, OP_CBZ, 1, 0);
    applyStimulus(0, OP_CBZ, 0, 0);
    applyStimulus(0, OP_CBZ, 0, 1);
    checkOutput("lit_cbz_pcwrite", PCWrite, 1);
    checkOutput("lit_cbz_pcsrc", PCSrc, 1);
    applyStimulus(0, OP_CBNZ, 1, 1);
    checkOutput("lit_cbz_retired", retired, 1);
    applyStimulus(0, OP_CBNZ, 0, 1);
    applyStimulus(0, OP_CBNZ, 0, 1);
    checkOutput("lit_cbnz_pcwrite", PCWrite, 0);
    checkOutput("lit_cbnz_pcsrc", PCSrc, 0);
    applyStimulus(0, OP_CBNZ, 0, 0);
    checkOutput("lit_cb_retired2", retired, 2);

    // Illegal opcode faults and stays faulted.
    applyStimulus(1, 11'd0, 0, 0);
    applyStimulus(0, 11'd0, 1, 0);
    applyStimulus(0, 11'd0, 0, 0);
    checkOutput("lit_ill_decode", state, 1);
    applyStimulus(0, 11'd0, 0, 0);
    checkOutput("lit_ill_fault_state", state, 6);
    checkOutput("lit_ill_fault_code", fault_code, 1);
    for (int i = 0; i < 19; i++) applyStimulus(0, randOp(), 1'($urandom), 1'($urandom));
    checkOutput("lit_ill_sticky", state, 6);
    checkOutput("lit_ill_fault_flag", fault, 1);

    // Fetch timeout after MEM_TIMEOUT waiting cycles.
    applyStimulus(1, OP_ADD, 0, 0);
    for (int i = 0; i < MEM_TIMEOUT; i++) applyStimulus(0, OP_ADD, 0, 0);
    checkOutput("lit_to_still_fetch", state, 0);
    applyStimulus(0, OP_ADD, 0, 0);
    checkOutput("lit_to_fault_state", state, 6);
    checkOutput("lit_to_fault_code", fault_code, 2);

    // HALT, then a one-cycle reset.
    applyStimulus(1, OP_HALT, 0, 0);
    applyStimulus(0, OP_HALT, 1, 0);
    applyStimulus(0, OP_HALT, 0, 0);
    applyStimulus(0, OP_HALT, 0, 0);
    checkOutput("lit_halt_halted", halted, 1);
    checkOutput("lit_halt_retired", retired, 1);
    checkOutput("lit_halt_instread", InstRead, 0);
    applyStimulus(1, OP_HALT, 0, 0);
    applyStimulus(0, OP_ADD, 0, 0);
    checkOutput("lit_postrst_state", state, 0);
    checkOutput("lit_postrst_retired", retired, 0);
    checkOutput("lit_postrst_instread", InstRead, 1);

    for (int c = 0; c < 4000; c++) begin
      logic rst;
      rst = ($urandom_range(0, 99) < 2) || (mState >= 5 && $urandom_range(0, 3) == 0);
      applyStimulus(rst, randOp(), $urandom_range(0, 9) < 6, 1'($urandom));
    end

    applyStimulus(0, OP_ADD, 0, 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/cpu_control_mc.md
CPU_CONTROL_MC -- requirements
Module: cpu_control_mc

Interface
REQ-001 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, maximum wait cycles for mem_ready before fault (legal range 1..255).
REQ-003 SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high.
REQ-004 SHALL have these data ports: inst31_21  in  11  opcode field, sampled in FETCH; mem_ready  in  1  memory handshake complete; zero  in  1  ALU zero flag.
REQ-005 SHALL have these strobe outputs, each 1 bit: InstRead, IRWrite, PCWrite, Reg2Loc, MemRead, MemWrite, MemtoReg, RegWrite.
REQ-006 SHALL have these encoded outputs: PCSrc  out  1  (0=PC+4, 1=branch target); ALUOp  out  2; ALUSrc  out  2.
REQ-007 SHALL have these status outputs: state  out  3  current state; halted  out  1; fault  out  1; fault_code  out  2  (0=none, 1=illegal opcode, 2=memory timeout); retired  out  CNT_W.

Function
REQ-008 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6; code 7 is unreachable and SHALL go to FAULT with fault_code=1.
REQ-009 SHALL decode from a latched opcode register as follows: LDUR=11111000010; STUR=11111000000; ADD=10001011000; SUB=11001011000; AND=10001010000; ORR=10101010000; ADDI=1001000100x; CBZ=10110100xxx; CBNZ=10110101xxx; B=000101xxxxx; HALT=11111111111.
REQ-010 In FETCH, InstRead SHALL be 1. On mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0; the opcode latch SHALL load inst31_21; next state DECODE.
REQ-011 In DECODE, each instruction SHALL go to its next state: illegal -> FAULT with fault_code=1; HALT -> HALT; B -> FETCH with PCWrite=1, PCSrc=1; all others -> EXEC.
REQ-012 In EXEC, ALUOp and ALUSrc SHALL be driven per instruction: LDUR/STUR 00/01; R-type 10/00; ADDI 10/10; CBZ/CBNZ 01/00. Reg2Loc SHALL be 1 for STUR, CBZ and CBNZ.
REQ-013 On leaving EXEC, next state SHALL be: R-type and ADDI -> WB; LDUR/STUR -> MEM; CBZ/CBNZ -> FETCH.
REQ-014 In EXEC for CBZ with zero=1, or CBNZ with zero=0, the block SHALL assert PCWrite=1 and PCSrc=1 for that cycle.
REQ-015 In MEM, MemRead (LDUR) or MemWrite (STUR) SHALL be held until mem_ready=1; then LDUR -> WB and STUR -> FETCH.
REQ-016 In WB, RegWrite SHALL be 1 for exactly one cycle, MemtoReg SHALL be 1 for LDUR only, and next state SHALL be FETCH.
REQ-017 In FETCH and MEM, a wait counter SHALL count cycles with mem_ready=0 and clear on state entry. When it reaches MEM_TIMEOUT, next state SHALL be FAULT with fault_code=2. mem_ready=1 in that same cycle SHALL take priority over the timeout.
REQ-018 HALT and FAULT SHALL be sticky until reset. In these states all strobes SHALL be 0; halted=1 in HALT; fault=1 in FAULT.
REQ-019 retired SHALL increment by 1 on every transition into FETCH from DECODE, EXEC, MEM or WB, and on entry to HALT. It SHALL wrap modulo 2^CNT_W.
REQ-020 Every strobe SHALL be asserted only in the states named above and SHALL be 0 otherwise. ALUOp and ALUSrc SHALL be 0 outside EXEC and MEM.
REQ-021 A mem_ready pulse received outside FETCH or MEM SHALL be ignored.

Reset
REQ-022 While reset=1 at a clock edge: state SHALL become FETCH; retired, the wait counter, the opcode latch and fault_code SHALL become 0; halted=0 and fault=0.
REQ-023 While reset=1, all strobe outputs SHALL be forced to 0 combinationally.
REQ-024 Reset asserted in any state, including mid-MEM with MemWrite=1, SHALL abort the instruction without incrementing retired.
REQ-025 The first cycle after reset deasserts SHALL present FETCH with InstRead=1.

Verification
REQ-026 ADD, mem_ready=1 in first FETCH cycle -> states 0,1,2,4,0; RegWrite=1 only in WB; retired 0->1.
REQ-027 LDUR, mem_ready delayed 3 cycles in MEM -> MemRead=1 for 4 cycles; WB with MemtoReg=1; retired=1.
REQ-028 CBZ with zero=1, then CBNZ with zero=1 -> PCWrite=1, PCSrc=1 in the first EXEC only; retired=2.
REQ-029 inst31_21=00000000000 -> FAULT after DECODE; fault_code=1; stays in FAULT for 20 cycles until reset.
REQ-030 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT entered after 4 waiting cycles, fault_code=2.
REQ-031 HALT opcode, then reset asserted one cycle -> halted=1, retired=1; after reset, state=0, retired=0, InstRead=1.
